// File: rtl/memory_arbiter.sv
// Two-requester (fetch / data) arbiter for a single shared memory port.
// Round-robin on ties, direct hand-over on completion, and a wait-cycle timeout.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IAck,
  output logic [31:0] IData,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic        DAck,
  output logic [31:0] DRData,
  output logic        MReadEnable,
  output logic        MWriteEnable,
  output logic [31:0] MAddr,
  output logic [31:0] MWData,
  input  logic [31:0] MRData,
  input  logic        MAck,
  output logic        Timeout
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       last_d, last_d_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       timeout_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      wait_cnt <= 8'd0;
      Timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_d   <= last_d_nxt;
      wait_cnt <= wait_cnt_nxt;
      Timeout  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_d_nxt   = last_d;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = 1'b0;
    MReadEnable  = 1'b0;
    MWriteEnable = 1'b0;
    MAddr        = 32'd0;
    MWData       = 32'd0;
    IAck         = 1'b0;
    IData        = 32'd0;
    DAck         = 1'b0;
    DRData       = 32'd0;

    case (state)
      IDLE: begin
        // On a tie the requester not served last wins
        if (IReq && (!DReq || last_d)) begin
          state_nxt    = GRANT_I;
          last_d_nxt   = 1'b0;
          wait_cnt_nxt = 8'd0;
        end else if (DReq) begin
          state_nxt    = GRANT_D;
          last_d_nxt   = 1'b1;
          wait_cnt_nxt = 8'd0;
        end
      end

      GRANT_I: begin
        MReadEnable = 1'b1;
        MAddr       = IAddr;
        if (MAck) begin
          IAck  = 1'b1;
          IData = MRData;
          if (DReq) begin
            state_nxt    = GRANT_D;
            last_d_nxt   = 1'b1;
            wait_cnt_nxt = 8'd0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end

      GRANT_D: begin
        MReadEnable  = ~DWrite;
        MWriteEnable = DWrite;
        MAddr        = DAddr;
        MWData       = DWrite ? DWData : 32'd0;
        if (MAck) begin
          DAck   = 1'b1;
          DRData = DWrite ? 32'd0 : MRData;
          if (IReq) begin
            state_nxt    = GRANT_I;
            last_d_nxt   = 1'b0;
            wait_cnt_nxt = 8'd0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
